pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic pipeline-stage register for the core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a CTRL_W control field plus a DATA_W payload from stage N to stage N+1
//  under a valid/ready handshake, with a synchronous flush.
//  Optional 2-entry skid buffer (SKID=1) registers up_ready, breaking the combinational
//  stall path. Saturating stall counter for performance analysis.
// PARAMETERS
//  CTRL_W  5   control bits (regwr, memtoreg, memwr, dmen, ...); forced to 0 in invalid/flushed entries
//  DATA_W  69  payload bits (e.g. result[31:0], rt[31:0], regdst_addr[4:0])
//  SKID    1   1: 2-entry skid buffer, registered up_ready; 0: single entry, combinational up_ready
//  CNT_W   16  stall counter width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  flush        in   1       discard all held entries (branch/exception kill)
//  up_valid     in   1       upstream stage presents an entry
//  up_ready     out  1       stage can accept; transfer when up_valid&up_ready
//  up_ctrl      in   CTRL_W  upstream control field
//  up_data      in   DATA_W  upstream payload
//  dn_valid     out  1       head entry valid toward downstream
//  dn_ready     in   1       downstream accepts; transfer when dn_valid&dn_ready
//  dn_ctrl      out  CTRL_W  head control; all-zero whenever dn_valid=0
//  dn_data      out  DATA_W  head payload; holds last value when dn_valid=0
//  occupancy    out  2       entries held (0..2; max 1 when SKID=0)
//  stall_cnt    out  CNT_W   cycles with dn_valid&!dn_ready, saturating
// BEHAVIOUR
//  Reset: dn_valid=0, dn_ctrl=0, dn_data=0, occupancy=0, stall_cnt=0, up_ready=1 in the first
//   cycle after reset; skid entry cleared.
//  Latency: an accepted entry appears on dn_* the next cycle (1-cycle register), never same-cycle.
//  SKID=1, states by occupancy:
//   EMPTY(0): up_ready=1. Accept -> FULL.
//   FULL(1):  up_ready=1. Accept&pop -> FULL (head replaced); accept&!pop -> SKID_FULL
//             (new entry into skid reg); pop&!accept -> EMPTY.
//   SKID_FULL(2): up_ready=0 (registered). Pop -> FULL, skid entry moves to head next cycle.
//  SKID=0: up_ready = !dn_valid | dn_ready (combinational); behaves like the classic
//   stall-able stage register; occupancy only 0/1.
//  Ordering: strict FIFO; an entry is never duplicated or dropped except by flush.
//  Flush: highest priority below reset. Next cycle occupancy=0, dn_valid=0, dn_ctrl=0; an
//   up transfer in the flush cycle is discarded; a dn transfer in the flush cycle still
//   completes (downstream already sampled it). dn_data is not cleared.
//  Simultaneous accept & pop in FULL: both occur; no bubble.
//  up_valid while up_ready=0: ignored, no state change; upstream holds its entry.
//  stall_cnt: +1 on each cycle with dn_valid&!dn_ready; holds at 2^CNT_W-1; cleared only by
//   reset (not flush).
//  Reset mid-operation overrides flush and handshakes; all held entries are lost.
//  Control zeroing on bubble guarantees no spurious regwr/memwr downstream.
// TESTING
//  1 Reset, then up_valid=1 ctrl=5'h1F data=A, dn_ready=1 -> next cycle dn_valid=1,
//    dn_ctrl=5'h1F, dn_data=A; stream of 8 entries back-to-back emerges in order, no gaps.
//  2 SKID=1, dn_ready=0, push A,B -> occupancy=2, up_ready=0 in cycle 3; C held upstream;
//    dn_ready=1 -> A, B, C drain in order, stall_cnt=number of stalled cycles.
//  3 Occupancy=2, flush=1 with up_valid=1 (D) -> next cycle dn_valid=0, dn_ctrl=0,
//    occupancy=0, D never appears on dn_*.
//  4 CNT_W=4, dn_valid=1 & dn_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds;
//    flush leaves it at 15; reset clears to 0.
//  5 SKID=0, dn_ready toggled 1,0,1,0 with continuous up_valid -> up_ready tracks
//    !dn_valid|dn_ready each cycle; every entry delivered exactly once.
//  6 Reset asserted with occupancy=2 and flush=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline-stage register between two core pipeline stages
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). It moves a control field plus a payload
//   from stage N to stage N+1 under a valid/ready handshake and supports a
//   synchronous flush.
//
//   With SKID=1 a second entry register absorbs the entry that arrives in the
//   same cycle downstream stalls. This lets up_ready come straight from a flop,
//   so the stall never ripples combinationally up the pipeline. With SKID=0
//   the stage is the classic single-entry stall-able register and up_ready is
//   combinational.
//
//   A saturating counter records the cycles in which the head entry is held
//   back by downstream.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   reset      in   synchronous, active-high
//   flush      in   discard all held entries (branch/exception kill)
//   up_valid   in   upstream presents an entry
//   up_ready   out  stage can accept; transfer on up_valid & up_ready
//   up_ctrl    in   upstream control field (CTRL_W)
//   up_data    in   upstream payload (DATA_W)
//   dn_valid   out  head entry valid toward downstream
//   dn_ready   in   downstream accepts; transfer on dn_valid & dn_ready
//   dn_ctrl    out  head control; all-zero whenever dn_valid=0
//   dn_data    out  head payload; keeps its last value when dn_valid=0
//   occupancy  out  entries held (0..2, at most 1 when SKID=0)
//   stall_cnt  out  saturating count of dn_valid & !dn_ready cycles
// ---------------------------------------------------------------------------

// One entry register: cleared on reset, loaded on demand, otherwise holds.
module pipe_stage_skid_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

module pipe_stage_skid #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 69,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int ENT_W = CTRL_W + DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    // The state encoding is the number of held entries, so it doubles as
    // the occupancy output.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t up_ent, hd_d, hd_ent, sk_ent;
    logic   hd_valid, accept, pop;
    logic   hd_load, hd_from_skid, sk_load;

    assign up_ent   = '{ctrl: up_ctrl, data: up_data};
    assign hd_valid = (state != EMPTY);
    assign accept   = up_valid & up_ready;
    assign pop      = hd_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Flush only suppresses loads and empties the stage; a pop in the same
    // cycle has already been seen downstream, so nothing else is undone.
    always_comb begin
        state_nxt    = state;
        hd_load      = 1'b0;
        hd_from_skid = 1'b0;
        sk_load      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = FULL;
                        hd_load   = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && pop) begin
                        hd_load = 1'b1;              // head replaced, no bubble
                    end else if (accept) begin
                        state_nxt = SKID_FULL;
                        sk_load   = 1'b1;            // head stalled, park the new one
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID_FULL: begin
                    // up_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_nxt    = FULL;
                        hd_load      = 1'b1;
                        hd_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign hd_d = hd_from_skid ? sk_ent : up_ent;

    pipe_stage_skid_entry #(.W(ENT_W)) u_head (
        .clk   (clk),
        .reset (reset),
        .load  (hd_load),
        .d     (hd_d),
        .q     (hd_ent)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            pipe_stage_skid_entry #(.W(ENT_W)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (sk_load),
                .d     (up_ent),
                .q     (sk_ent)
            );

            // Ready for next cycle is decided now from the next state, so the
            // port is a plain flop output with no path from dn_ready.
            always_ff @(posedge clk) begin
                if (reset) rdy_q <= 1'b1;
                else       rdy_q <= (state_nxt != SKID_FULL);
            end

            assign up_ready = rdy_q;
        end else begin : g_noskid
            // Without a skid slot the stage can only take a new entry when the
            // head is empty or leaving this cycle, so SKID_FULL is unreachable.
            logic unused_sk_load;
            assign unused_sk_load = sk_load;
            assign sk_ent         = '0;
            assign up_ready       = ~hd_valid | dn_ready;
        end
    endgenerate

    // Zeroing ctrl on a bubble keeps regwr/memwr from firing downstream.
    assign dn_valid  = hd_valid;
    assign dn_ctrl   = hd_valid ? hd_ent.ctrl : '0;
    assign dn_data   = hd_ent.data;
    assign occupancy = state;

    // Only reset clears the counter; flush must not hide stall history.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hd_valid && !dn_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Drives a SKID=1 and a SKID=0 instance (both CNT_W=4) with the same
//   inputs. Directed phases are followed by a random phase. A queue-based
//   reference model per instance holds the entries the stage should contain;
//   a monitor compares every output each cycle against it.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
    localparam int CW = 5;
    localparam int DW = 69;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset, flush, up_valid, dn_ready;
    logic [CW-1:0] up_ctrl;
    logic [DW-1:0] up_data;

    logic          ur   [2];
    logic          dv   [2];
    logic [CW-1:0] dc   [2];
    logic [DW-1:0] dd   [2];
    logic [1:0]    occ  [2];
    logic [NW-1:0] scnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .up_valid(up_valid), .up_ready(ur[0]), .up_ctrl(up_ctrl), .up_data(up_data),
        .dn_valid(dv[0]), .dn_ready(dn_ready), .dn_ctrl(dc[0]), .dn_data(dd[0]),
        .occupancy(occ[0]), .stall_cnt(scnt[0])
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)) u_noskid (
        .clk(clk), .reset(reset), .flush(flush),
        .up_valid(up_valid), .up_ready(ur[1]), .up_ctrl(up_ctrl), .up_data(up_data),
        .dn_valid(dv[1]), .dn_ready(dn_ready), .dn_ctrl(dc[1]), .dn_data(dd[1]),
        .occupancy(occ[1]), .stall_cnt(scnt[1])
    );

    task automatic chk(input string nm, input int k, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard / reference model --------------------------
    // sb[k] holds, oldest first, the entries instance k should be holding.
    // Capacity rule: SKID=1 accepts while fewer than 2 are held (decided from
    // the held count alone); SKID=0 accepts when empty or when the head leaves.
    ent_t          sb [2][$];
    int            cnt  [2] = '{0, 0};
    logic [DW-1:0] last [2] = '{'0, '0};
    bit            armed = 0;

    initial begin
        int   n;
        bit   rdy;
        ent_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n   = sb[k].size();
                rdy = (k == 0) ? (n < 2) : (n == 0 || dn_ready);
                if (armed) begin
                    chk("dn_valid",  k, 80'(dv[k]),  80'(n != 0));
                    chk("dn_ctrl",   k, 80'(dc[k]),  80'((n != 0) ? sb[k][0].ctrl : '0));
                    chk("dn_data",   k, 80'(dd[k]),  80'((n != 0) ? sb[k][0].data : last[k]));
                    chk("occupancy", k, 80'(occ[k]), 80'(n));
                    chk("up_ready",  k, 80'(ur[k]),  80'(rdy));
                    chk("stall_cnt", k, 80'(scnt[k]), 80'(cnt[k]));
                end
                // Advance the model to the state after the coming clock edge.
                if (reset) begin
                    sb[k].delete();
                    cnt[k]  = 0;
                    last[k] = '0;
                end else begin
                    if (n != 0) last[k] = sb[k][0].data;
                    if (n != 0 && !dn_ready && cnt[k] < SAT) cnt[k]++;
                    if (n != 0 && dn_ready) e = sb[k].pop_front();
                    if (flush) begin
                        sb[k].delete();
                    end else if (up_valid && rdy) begin
                        e.ctrl = up_ctrl;
                        e.data = up_data;
                        sb[k].push_back(e);
                    end
                end
            end
            if (reset) armed = 1;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic drive(input bit uv, input bit dr, input bit fl, input bit rs,
                         input logic [CW-1:0] c);
        up_valid = uv;
        dn_ready = dr;
        flush    = fl;
        reset    = rs;
        up_ctrl  = c;
        up_data  = {5'($urandom), $urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] rc();
        return CW'($urandom);
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_ctrl = '0; up_data = '0;
        repeat (3) drive(0, 0, 0, 1, rc());

        // Back-to-back stream of 8 with downstream always ready.
        drive(1, 1, 0, 0, 5'h1F);
        for (int i = 1; i < 8; i++) drive(1, 1, 0, 0, rc());
        repeat (3) drive(0, 1, 0, 0, rc());

        // Stall with dn_ready low: fill the skid, upstream keeps offering, then drain.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, rc());
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, rc());
        repeat (4) drive(0, 1, 0, 0, rc());

        // Full skid, then flush with a new entry offered in the same cycle.
        drive(1, 0, 0, 0, rc());
        drive(1, 0, 0, 0, rc());
        drive(1, 0, 1, 0, rc());
        repeat (2) drive(0, 1, 0, 0, rc());

        // Long stall: the 4-bit counter saturates, flush keeps it, reset clears it.
        drive(1, 0, 0, 0, rc());
        repeat (20) drive(0, 0, 0, 0, rc());
        drive(0, 0, 1, 0, rc());
        repeat (2) drive(0, 0, 0, 0, rc());
        drive(0, 0, 0, 1, rc());
        drive(0, 1, 0, 0, rc());

        // Alternating downstream ready with upstream always valid.
        for (int i = 0; i < 12; i++) drive(1, (i % 2) == 0, 0, 0, rc());
        repeat (4) drive(0, 1, 0, 0, rc());

        // Reset together with flush while the skid is full.
        drive(1, 0, 0, 0, rc());
        drive(1, 0, 0, 0, rc());
        drive(1, 0, 1, 1, rc());
        drive(0, 0, 0, 0, rc());

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0, rc());
        end
        repeat (4) drive(0, 1, 0, 0, rc());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
